// File: rtl/piso_tx_pkg.sv
// Shared definitions for the PISO transmit scheduler: state encoding and
// a modular increment helper for round-robin pointers.
package piso_tx_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
   endfunction

endpackage

// File: rtl/piso_tx_scheduler_if.sv
// Requester handshake and serial link bundle for the PISO transmit scheduler.
interface piso_tx_scheduler_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned ID_W  = 2
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  ser_out;
   logic                  ser_valid;
   logic                  ser_first;
   logic                  ser_last;
   logic [ID_W-1:0]       ser_src;
   logic                  busy;

   modport master (
      output req_valid, req_data,
      input  req_ready, ser_out, ser_valid, ser_first, ser_last, ser_src, busy
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, ser_out, ser_valid, ser_first, ser_last, ser_src, busy
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// above ptr, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] grant_id,
   output logic            any
);
   logic [ID_W-1:0] cand;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      cand     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = ID_W'((32'(ptr) + k) % NREQ);
         if (en && !any && req[cand]) begin
            any         = 1'b1;
            grant_id    = cand;
            grant[cand] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one LSB-first shift datapath between NREQ
// parallel requesters; back-to-back words stream with no idle gap.
module piso_tx_scheduler
   import piso_tx_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SEL   = 3,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic               clock,
   input  logic               reset,
   piso_tx_scheduler_if.slave bus
);
   localparam logic [SEL-1:0] LAST_IDX = SEL'(WIDTH - 1);

   logic             state, state_nxt;
   logic [SEL-1:0]   idx, idx_nxt, idx_inc;
   logic [ID_W-1:0]  ptr, src_q;
   logic [WIDTH-1:0] shreg, load_word;
   logic             at_last, grant_en, xfer;
   logic [NREQ-1:0]  grant;
   logic [ID_W-1:0]  grant_id;
   logic             out_q, first_q, last_q;
   logic             out_nxt, first_nxt, last_nxt;

   assign at_last  = (idx == LAST_IDX);
   assign idx_inc  = idx + SEL'(1);
   // Grants are suppressed while reset is held so no transfer can be pending.
   assign grant_en = ((state == ST_IDLE) || at_last) && !reset;

   rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
      .req      (bus.req_valid),
      .ptr      (ptr),
      .en       (grant_en),
      .grant    (grant),
      .grant_id (grant_id),
      .any      (xfer)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (xfer)                               state_nxt = ST_SHIFT;
      else if ((state == ST_SHIFT) && at_last) state_nxt = ST_IDLE;
   end

   // Next values of the registered serial outputs; ser_out tracks word[idx].
   always_comb begin
      bus.req_ready = grant;
      load_word     = '0;
      out_nxt       = 1'b0;
      first_nxt     = 1'b0;
      last_nxt      = 1'b0;
      idx_nxt       = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) load_word = bus.req_data[i*WIDTH +: WIDTH];
      end
      if (xfer) begin
         out_nxt   = load_word[0];
         first_nxt = 1'b1;
         last_nxt  = (LAST_IDX == '0);
      end else if ((state == ST_SHIFT) && !at_last) begin
         idx_nxt  = idx_inc;
         out_nxt  = shreg[idx_inc];
         last_nxt = (idx_inc == LAST_IDX);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx     <= '0;
         ptr     <= '0;
         shreg   <= '0;
         src_q   <= '0;
         out_q   <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         idx     <= idx_nxt;
         out_q   <= out_nxt;
         first_q <= first_nxt;
         last_q  <= last_nxt;
         if (xfer) begin
            shreg <= load_word;
            src_q <= grant_id;
            ptr   <= ID_W'(wrap_inc(32'(grant_id), NREQ));
         end
      end
   end

   assign bus.ser_out   = out_q;
   assign bus.ser_valid = state;
   assign bus.ser_first = first_q;
   assign bus.ser_last  = last_q;
   assign bus.ser_src   = src_q;
   assign bus.busy      = state;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: directed scenarios plus random traffic, all
// checked against a queue-of-bits reference model of the serial stream.
module tb_piso_tx_scheduler;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned SEL   = 3;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned ID_W  = 2;

   typedef struct {
      logic b;
      logic f;
      logic l;
   } bit_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   piso_tx_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W)) bus8 ();
   piso_tx_scheduler_if #(.WIDTH(4), .NREQ(2), .ID_W(1)) bus4 ();

   piso_tx_scheduler #(.WIDTH(WIDTH), .SEL(SEL), .NREQ(NREQ), .ID_W(ID_W)) dut8 (
      .clock (clk),
      .reset (rst),
      .bus   (bus8)
   );

   piso_tx_scheduler #(.WIDTH(4), .SEL(2), .NREQ(2), .ID_W(1)) dut4 (
      .clock (clk),
      .reset (rst),
      .bus   (bus4)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: expected serial bits still to appear, rr pointer, last source.
   bit_t q[$];
   int   ptr;
   int   last_src;
   int   last_grant;

   logic            obs_out, obs_first, obs_last, obs_valid;
   logic [ID_W-1:0] obs_src;
   logic [NREQ-1:0] obs_rdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, 32'(bus8.req_ready), 0);
      chk({tag, "_valid"}, 32'(bus8.ser_valid), 0);
      chk({tag, "_out"},   32'(bus8.ser_out),   0);
      chk({tag, "_first"}, 32'(bus8.ser_first), 0);
      chk({tag, "_last"},  32'(bus8.ser_last),  0);
      chk({tag, "_src"},   32'(bus8.ser_src),   0);
      chk({tag, "_busy"},  32'(bus8.busy),      0);
   endtask

   task automatic model_reset();
      q.delete();
      ptr      = 0;
      last_src = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus8.req_valid = '0;
      bus8.req_data  = '0;
      bus4.req_valid = '0;
      bus4.req_data  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance it.
   task automatic step();
      int              g;
      logic [NREQ-1:0] exp_rdy;
      logic [WIDTH-1:0] w;
      @(negedge clk);
      g       = -1;
      exp_rdy = '0;
      w       = '0;
      if (q.size() <= 1) begin
         for (int k = 0; k < int'(NREQ); k++) begin
            int j;
            j = (ptr + k) % int'(NREQ);
            if (g < 0 && bus8.req_valid[j]) g = j;
         end
      end
      if (g >= 0) begin
         exp_rdy[g] = 1'b1;
         w = bus8.req_data[g*WIDTH +: WIDTH];
      end
      obs_rdy   = bus8.req_ready;
      obs_out   = bus8.ser_out;
      obs_first = bus8.ser_first;
      obs_last  = bus8.ser_last;
      obs_valid = bus8.ser_valid;
      obs_src   = bus8.ser_src;
      chk("req_ready", 32'(obs_rdy), 32'(exp_rdy));
      chk("ser_valid", 32'(obs_valid), (q.size() > 0) ? 1 : 0);
      chk("busy",      32'(bus8.busy), (q.size() > 0) ? 1 : 0);
      chk("ser_out",   32'(obs_out),   (q.size() > 0) ? 32'(q[0].b) : 0);
      chk("ser_first", 32'(obs_first), (q.size() > 0) ? 32'(q[0].f) : 0);
      chk("ser_last",  32'(obs_last),  (q.size() > 0) ? 32'(q[0].l) : 0);
      chk("ser_src",   32'(obs_src),   32'(last_src));
      last_grant = g;
      @(posedge clk);
      if (q.size() > 0) q.delete(0);
      if (g >= 0) begin
         for (int k = 0; k < int'(WIDTH); k++)
            q.push_back(bit_t'{b: w[k], f: (k == 0), l: (k == int'(WIDTH) - 1)});
         ptr      = (g + 1) % int'(NREQ);
         last_src = g;
      end
      #1;
   endtask

   // Producers hold a pending word, occasionally withdraw, and refresh after a grant.
   task automatic rand_inputs(input int g);
      for (int i = 0; i < int'(NREQ); i++) begin
         if (i == g) begin
            bus8.req_valid[i] = 1'($urandom_range(0, 1));
            bus8.req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         end else if (bus8.req_valid[i]) begin
            if ($urandom_range(0, 15) == 0) bus8.req_valid[i] = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            bus8.req_valid[i] = 1'b1;
            bus8.req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         end
      end
   endtask

   initial begin
      logic [WIDTH-1:0] word;
      logic [3:0]       d4;
      int               gl[$];
      int               vcnt;

      // Single word from requester 0.
      do_reset();
      bus8.req_valid = 4'b0001;
      bus8.req_data[7:0] = 8'hA5;
      step();
      chk("t1_grant", 32'(last_grant), 0);
      bus8.req_valid = '0;
      for (int k = 0; k < int'(WIDTH); k++) begin
         step();
         word[k] = obs_out;
      end
      chk("t1_word", 32'(word), 32'hA5);
      step();
      chk("t1_idle", 32'(obs_valid), 0);

      // All requesters continuously valid.
      do_reset();
      bus8.req_valid = 4'b1111;
      bus8.req_data  = {8'h08, 8'h04, 8'h02, 8'h01};
      gl.delete();
      vcnt = 0;
      for (int s = 0; s < 37; s++) begin
         step();
         if (last_grant >= 0) gl.push_back(last_grant);
         if (s > 0 && obs_valid) vcnt++;
      end
      chk("t2_nogap", 32'(vcnt), 36);
      chk("t2_g0", 32'(gl[0]), 0);
      chk("t2_g1", 32'(gl[1]), 1);
      chk("t2_g2", 32'(gl[2]), 2);
      chk("t2_g3", 32'(gl[3]), 3);
      chk("t2_g4", 32'(gl[4]), 0);

      // Pointer past requester 1 favours requester 3.
      do_reset();
      bus8.req_valid = 4'b0010;
      bus8.req_data  = {8'hC3, 8'h00, 8'h3C, 8'h00};
      gl.delete();
      step();
      if (last_grant >= 0) gl.push_back(last_grant);
      bus8.req_valid = 4'b1010;
      for (int s = 0; s < 20; s++) begin
         step();
         if (last_grant >= 0) gl.push_back(last_grant);
      end
      chk("t3_g0", 32'(gl[0]), 1);
      chk("t3_g1", 32'(gl[1]), 3);
      chk("t3_g2", 32'(gl[2]), 1);

      // Asynchronous reset during bit 3.
      do_reset();
      bus8.req_valid = 4'b0001;
      bus8.req_data[7:0] = 8'hFF;
      step();
      bus8.req_valid = 4'b0100;
      bus8.req_data[23:16] = 8'h5A;
      repeat (3) step();
      @(negedge clk);
      chk("t4_bit3_valid", 32'(bus8.ser_valid), 1);
      #2 rst = 1'b1;
      #1 chk_zero("t4_async");
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      chk("t4_grant2", 32'(last_grant), 2);
      bus8.req_valid = '0;
      repeat (9) step();

      // Late request joins at the last bit with no idle gap.
      do_reset();
      bus8.req_valid = 4'b0001;
      bus8.req_data[7:0] = 8'h96;
      step();
      bus8.req_valid = '0;
      repeat (5) step();
      bus8.req_valid = 4'b0100;
      bus8.req_data[23:16] = 8'h3C;
      step();
      chk("t5_rdy_bit5", 32'(obs_rdy), 0);
      step();
      step();
      chk("t5_rdy_bit7", 32'(obs_rdy), 32'h4);
      bus8.req_valid = '0;
      step();
      chk("t5_next_first", 32'(obs_first), 1);
      chk("t5_next_src", 32'(obs_src), 2);
      chk("t5_next_valid", 32'(obs_valid), 1);
      repeat (8) step();

      // Narrow instance: 4-bit word from requester 1.
      d4 = 4'hC;
      bus4.req_valid = 2'b10;
      bus4.req_data  = {d4, 4'h0};
      @(negedge clk);
      chk("t6_ready", 32'(bus4.req_ready), 32'h2);
      @(posedge clk);
      #1 bus4.req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t6_out",   32'(bus4.ser_out),   32'(d4[k]));
         chk("t6_src",   32'(bus4.ser_src),   1);
         chk("t6_first", 32'(bus4.ser_first), (k == 0) ? 1 : 0);
         chk("t6_last",  32'(bus4.ser_last),  (k == 3) ? 1 : 0);
      end
      @(negedge clk);
      chk("t6_idle", 32'(bus4.ser_valid), 0);

      // Random traffic against the model.
      do_reset();
      for (int s = 0; s < 1500; s++) begin
         step();
         rand_inputs(last_grant);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
